// File: rtl/dmem_arbiter.sv
// Data-RAM port arbiter between the MEM-stage CPU access and a debug/loader
// burst port, with bounded debug starvation.
module dmem_arbiter #(
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [3:0]  dbg_len,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_wready,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_done,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    input  logic [31:0] ram_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [4:0]    MAXB = 5'(MAX_BURST);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t        state_q;
    logic [31:0]   base_q;
    logic          we_q;
    logic [4:0]    len_q;
    logic [4:0]    beat_q;
    logic [SW-1:0] starve_q;
    logic          gnt_q;
    logic          rvalid_q;
    logic          done_q;
    logic [31:0]   rdata_q;

    logic [4:0]    len_d;
    logic          grant;
    logic          last_beat;
    logic [31:0]   burst_addr;

    // Zero-length means one word; oversize requests clamp to the burst cap.
    always_comb begin
        len_d = {1'b0, dbg_len};
        if (len_d == 5'd0) begin
            len_d = 5'd1;
        end else if (len_d > MAXB) begin
            len_d = MAXB;
        end
    end

    assign grant = (state_q == IDLE) & dbg_req
                 & (~cpu_req | (starve_q == SLIM));

    assign last_beat  = (beat_q == (len_q - 5'd1)) | ~dbg_req;
    assign burst_addr = base_q + (32'(beat_q) << 2);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            we_q     <= 1'b0;
            len_q    <= '0;
            beat_q   <= '0;
            starve_q <= '0;
            gnt_q    <= 1'b0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            if (!dbg_req) begin
                starve_q <= '0;
            end
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        base_q   <= dbg_addr;
                        we_q     <= dbg_we;
                        len_q    <= len_d;
                        beat_q   <= '0;
                        starve_q <= '0;
                        gnt_q    <= 1'b1;
                        state_q  <= BURST;
                    end else if (dbg_req && cpu_req && starve_q != SLIM) begin
                        starve_q <= starve_q + 1'b1;
                    end
                end
                BURST: begin
                    if (!we_q) begin
                        rdata_q  <= ram_rdata;
                        rvalid_q <= 1'b1;
                    end
                    if (last_beat) begin
                        gnt_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        beat_q <= beat_q + 5'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        ram_addr   = cpu_addr;
        ram_wdata  = cpu_wdata;
        ram_we     = cpu_req & cpu_we;
        cpu_rdata  = ram_rdata;
        cpu_stall  = 1'b0;
        dbg_wready = 1'b0;
        if (state_q == BURST) begin
            ram_addr   = burst_addr;
            ram_wdata  = dbg_wdata;
            ram_we     = we_q;
            cpu_rdata  = '0;
            cpu_stall  = cpu_req;
            dbg_wready = we_q;
        end
    end

    assign dbg_gnt    = gnt_q;
    assign dbg_rvalid = rvalid_q;
    assign dbg_rdata  = rdata_q;
    assign dbg_done   = done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scenario bench for dmem_arbiter: expected beats and read data are queued
// when a burst is issued and consumed as the DUT produces them.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr;
    logic [3:0]  dbg_len;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt, dbg_wready, dbg_rvalid, dbg_done;
    logic [31:0] dbg_rdata;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we;

    logic        rd_ovr_en;
    logic [31:0] rd_ovr;
    localparam logic [31:0] RK = 32'hC3A5_5A3C;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] addr_q[$];
    logic [31:0] rd_q[$];

    // Same-cycle RAM model: data is a fixed scramble of the address.
    assign ram_rdata = rd_ovr_en ? rd_ovr : (ram_addr ^ RK);

    always #5 clock = ~clock;

    dmem_arbiter #(.MAX_BURST(8), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_len(dbg_len), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
        .dbg_wready(dbg_wready), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_len = 0; dbg_wdata = 0;
        rd_ovr_en = 0; rd_ovr = 0;
        step(); step();
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({dbg_gnt, dbg_rvalid, dbg_done, cpu_stall} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {dbg_gnt, dbg_rvalid, dbg_done, cpu_stall});
        end
        n_checks++;
        if (dbg_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 0", dbg_rdata);
        end
    endtask

    task automatic test_cpu_only();
        step();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        rd_ovr_en = 1; rd_ovr = 32'hDEADBEEF;
        @(negedge clock);
        n_checks++;
        if (cpu_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL cpu_rdata: got %h want deadbeef", cpu_rdata);
        end
        n_checks++;
        if (cpu_stall !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL cpu_read_port: stall=%b we=%b addr=%h want 0 0 10",
                     cpu_stall, ram_we, ram_addr);
        end
        step();
        cpu_we = 1; cpu_addr = 32'h24; cpu_wdata = 32'h1234_5678;
        @(negedge clock);
        n_checks++;
        if (ram_we !== 1'b1 || ram_wdata !== 32'h1234_5678
            || ram_addr !== 32'h24 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_write_port: we=%b wd=%h addr=%h stall=%b",
                     ram_we, ram_wdata, ram_addr, cpu_stall);
        end
        step();
        cpu_req = 0; cpu_we = 0; rd_ovr_en = 0;
    endtask

    task automatic run_burst(input string name, input logic we,
                             input logic [31:0] base, input logic [3:0] len,
                             input int drop_after, input int nexp);
        int beats;
        int cyc;
        bit done_seen;
        logic [31:0] ea;
        logic [31:0] ed;
        step();
        for (int i = 0; i < nexp; i++) begin
            addr_q.push_back(base + 32'(i * 4));
            if (!we) rd_q.push_back((base + 32'(i * 4)) ^ RK);
        end
        dbg_req = 1; dbg_we = we; dbg_addr = base; dbg_len = len;
        dbg_wdata = 32'h5000_0000;
        beats = 0; done_seen = 0; cyc = 0;
        while (!done_seen && cyc < 40) begin
            @(negedge clock);
            if (cyc == 0) begin
                n_checks++;
                if (dbg_gnt !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_grant_cycle: gnt=%b want 0", name, dbg_gnt);
                end
            end
            if (dbg_gnt === 1'b1) begin
                beats++;
                ea = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hBAD0_BAD0;
                n_checks++;
                if (ram_addr !== ea || ram_we !== we || dbg_wready !== we
                    || ram_wdata !== dbg_wdata || cpu_rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL %s_beat%0d: addr=%h/%h we=%b wr=%b wd=%h/%h crd=%h",
                             name, beats, ram_addr, ea, ram_we, dbg_wready,
                             ram_wdata, dbg_wdata, cpu_rdata);
                end
            end
            if (dbg_rvalid === 1'b1) begin
                ed = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hBAD1_BAD1;
                n_checks++;
                if (dbg_rdata !== ed) begin
                    n_fail++;
                    $display("FAIL %s_rdata: got %h want %h", name, dbg_rdata, ed);
                end
            end
            if (dbg_done === 1'b1) begin
                done_seen = 1;
                n_checks++;
                if (dbg_gnt !== 1'b0 || dbg_rvalid !== ~we) begin
                    n_fail++;
                    $display("FAIL %s_done_cycle: gnt=%b rvalid=%b want 0 %b",
                             name, dbg_gnt, dbg_rvalid, ~we);
                end
            end
            step();
            cyc++;
            dbg_wdata = dbg_wdata + 32'd1;
            if (beats == drop_after) dbg_req = 0;
        end
        dbg_req = 0;
        n_checks++;
        if (!done_seen) begin
            n_fail++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, cyc);
        end
        n_checks++;
        if (beats != nexp || addr_q.size() != 0 || rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_beats: got %0d want %0d (left addr=%0d rd=%0d)",
                     name, beats, nexp, addr_q.size(), rd_q.size());
        end
        addr_q.delete();
        rd_q.delete();
        @(negedge clock);
        n_checks++;
        if (dbg_done !== 1'b0 || dbg_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after: done=%b gnt=%b want 0 0", name, dbg_done, dbg_gnt);
        end
    endtask

    task automatic test_starvation();
        step();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80;
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h300; dbg_len = 2;
        dbg_wdata = 32'hA0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            n_checks++;
            if (dbg_gnt !== 1'b0 || cpu_stall !== 1'b0 || ram_addr !== 32'h80) begin
                n_fail++;
                $display("FAIL starve_wait%0d: gnt=%b stall=%b addr=%h",
                         c, dbg_gnt, cpu_stall, ram_addr);
            end
            step();
        end
        for (int b = 0; b < 2; b++) begin
            @(negedge clock);
            n_checks++;
            if (dbg_gnt !== 1'b1 || cpu_stall !== 1'b1
                || ram_addr !== 32'h300 + 32'(b * 4) || ram_we !== 1'b1) begin
                n_fail++;
                $display("FAIL starve_beat%0d: gnt=%b stall=%b addr=%h we=%b",
                         b, dbg_gnt, cpu_stall, ram_addr, ram_we);
            end
            step();
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            n_checks++;
            if (dbg_gnt !== 1'b0 || cpu_stall !== 1'b0 || dbg_done !== (c == 0)
                || cpu_rdata !== (32'h80 ^ RK)) begin
                n_fail++;
                $display("FAIL starve_cpu_gap%0d: gnt=%b stall=%b done=%b rd=%h",
                         c, dbg_gnt, cpu_stall, dbg_done, cpu_rdata);
            end
            step();
        end
        cpu_req = 0; dbg_req = 0;
        step(); step();
    endtask

    task automatic test_back_to_back();
        step();
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h400; dbg_len = 1;
        step();
        @(negedge clock);
        n_checks++;
        if (dbg_gnt !== 1'b1 || ram_addr !== 32'h400) begin
            n_fail++;
            $display("FAIL b2b_first: gnt=%b addr=%h", dbg_gnt, ram_addr);
        end
        step();
        @(negedge clock);
        n_checks++;
        if (dbg_done !== 1'b1 || dbg_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b gnt=%b want 1 0", dbg_done, dbg_gnt);
        end
        step();
        @(negedge clock);
        n_checks++;
        if (dbg_gnt !== 1'b1 || ram_addr !== 32'h400 || dbg_done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_regrant: gnt=%b addr=%h done=%b",
                     dbg_gnt, ram_addr, dbg_done);
        end
        step();
        dbg_req = 0;
        @(negedge clock);
        n_checks++;
        if (dbg_done !== 1'b1 || dbg_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_done: done=%b gnt=%b", dbg_done, dbg_gnt);
        end
        step();
    endtask

    task automatic test_reset_mid_burst();
        step();
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h200; dbg_len = 8;
        step(); step(); step();
        @(negedge clock);
        n_checks++;
        if (dbg_gnt !== 1'b1 || ram_addr !== 32'h208) begin
            n_fail++;
            $display("FAIL rst_pre: gnt=%b addr=%h want 1 208", dbg_gnt, ram_addr);
        end
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ram_we !== 1'b0 || dbg_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: we=%b gnt=%b stall=%b want 0 0 0",
                     ram_we, dbg_gnt, cpu_stall);
        end
        dbg_req = 0;
        step(); step();
        reset = 1'b0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h44; cpu_wdata = 32'hCAFE_0044;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            n_checks++;
            if (dbg_done !== 1'b0 || dbg_gnt !== 1'b0 || ram_addr !== 32'h44
                || ram_we !== 1'b1 || ram_wdata !== 32'hCAFE_0044) begin
                n_fail++;
                $display("FAIL rst_release%0d: done=%b gnt=%b addr=%h we=%b wd=%h",
                         c, dbg_done, dbg_gnt, ram_addr, ram_we, ram_wdata);
            end
            step();
        end
        cpu_req = 0; cpu_we = 0;
    endtask

    initial begin
        test_reset();
        test_cpu_only();
        run_burst("wr4", 1'b1, 32'h0000_0100, 4'd4, 4, 4);
        test_starvation();
        run_burst("rdwrap", 1'b0, 32'hFFFF_FFF8, 4'd3, 3, 3);
        run_burst("abort", 1'b0, 32'h0000_0600, 4'd8, 2, 3);
        run_burst("len0", 1'b1, 32'h0000_0700, 4'd0, 1, 1);
        run_burst("len12", 1'b0, 32'h0000_0800, 4'd12, 8, 8);
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
